// File: rtl/res_station_cmp_age_pkg.sv
// Shared types for the compare/branch reservation station: entry layout, CDB broadcast,
// branch tags and the selective-flush kill rule.
package res_station_cmp_age_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ROB_IDX_W = 3;
  localparam int unsigned BR_TAG_W  = 4;

  // MSB of a branch tag is its sign; the remaining bits form the dependency mask.
  typedef logic [BR_TAG_W-1:0] branch_tag_t;

  localparam logic [2:0] CmpBeq  = 3'd0;
  localparam logic [2:0] CmpBne  = 3'd1;
  localparam logic [2:0] CmpBlt  = 3'd4;
  localparam logic [2:0] CmpBge  = 3'd5;
  localparam logic [2:0] CmpBltu = 3'd6;
  localparam logic [2:0] CmpBgeu = 3'd7;

  typedef struct packed {
    logic                 commit_valid;
    logic [ROB_IDX_W-1:0] dest_ROB;
    logic [XLEN-1:0]      rd_v;
  } CDB_output_t;

  typedef struct packed {
    logic                 rs1_ready;
    logic [XLEN-1:0]      rs1_data;
    logic                 rs2_ready;
    logic [XLEN-1:0]      rs2_data;
    branch_tag_t          br_tag;
    logic [ROB_IDX_W-1:0] dest_rob;
    logic                 cmp_type;
    logic [2:0]           cmp_op;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      pc;
  } rs_cmp_entry_t;

  function automatic logic cmp_flush_kill(branch_tag_t tag, branch_tag_t ftag);
    if (tag[BR_TAG_W-1] == ftag[BR_TAG_W-1]) return (tag & ftag) == ftag;
    return (tag & ftag) == tag;
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: tracks dispatch order of DEPTH slots and grants the oldest requester.
module rs_age_matrix #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free_mask,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);

  // older_q[i][j] set means slot i was dispatched before slot j.
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      older_d[i] = free_mask[i] ? '0 : older_q[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc[i]) begin
        older_d[i] = '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (j != i) older_d[j][i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (req[j] && older_q[j][i]) blocked = 1'b1;
      end
      grant[i] = req[i] && !blocked;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) older_q <= '{default: '0};
    else     older_q <= older_d;
  end

endmodule

// File: rtl/res_station_cmp_age.sv
// Compare/branch reservation station: CDB wake-up, oldest-ready issue, selective flush.
// Define RS_CMP_BYPASS_EN to let an operand arriving on the CDB issue in the same cycle.
module res_station_cmp_age
  import res_station_cmp_age_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ROB_WIDTH = 3,
  parameter int unsigned NUM_CDB   = 2,
  localparam int unsigned OccW     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  branch_tag_t          flush_tag,
  input  logic                 disp_valid,
  input  rs_cmp_entry_t        disp_entry,
  output logic                 rs_ready,
  input  CDB_output_t          cdb [NUM_CDB],
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [XLEN-1:0]      iss_op1,
  output logic [XLEN-1:0]      iss_op2,
  output branch_tag_t          iss_br_tag,
  output logic [ROB_WIDTH-1:0] iss_dest_rob,
  output logic                 iss_cmp_type,
  output logic [2:0]           iss_cmp_op,
  output logic [XLEN-1:0]      iss_imm,
  output logic [XLEN-1:0]      iss_pc,
  output logic [OccW-1:0]      occupancy
);

  logic [DEPTH-1:0] valid_q, valid_d;
  rs_cmp_entry_t    entry_q [DEPTH];
  rs_cmp_entry_t    entry_d [DEPTH];
  rs_cmp_entry_t    woke    [DEPTH];
  rs_cmp_entry_t    sel_src [DEPTH];
  rs_cmp_entry_t    disp_woke;
  logic [DEPTH-1:0] kill, req, grant, alloc, alloc_sel, free_mask;
  logic             disp_kill, disp_ok, fire;

  // Lowest-numbered matching CDB port wins, hence the descending scan.
  function automatic rs_cmp_entry_t snoop(rs_cmp_entry_t e);
    rs_cmp_entry_t r;
    r = e;
    for (int k = int'(NUM_CDB) - 1; k >= 0; k--) begin
      if (cdb[k].commit_valid) begin
        if (!e.rs1_ready && e.rs1_data[ROB_WIDTH-1:0] == cdb[k].dest_ROB[ROB_WIDTH-1:0]) begin
          r.rs1_ready = 1'b1;
          r.rs1_data  = cdb[k].rd_v;
        end
        if (!e.rs2_ready && e.rs2_data[ROB_WIDTH-1:0] == cdb[k].dest_ROB[ROB_WIDTH-1:0]) begin
          r.rs2_ready = 1'b1;
          r.rs2_data  = cdb[k].rd_v;
        end
      end
    end
    return r;
  endfunction

  assign rs_ready = |(~valid_q);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = snoop(entry_q[i]);
      kill[i] = flush && cmp_flush_kill(entry_q[i].br_tag, flush_tag);
`ifdef RS_CMP_BYPASS_EN
      sel_src[i] = woke[i];
`else
      sel_src[i] = entry_q[i];
`endif
      req[i] = !rst && valid_q[i] && !kill[i] && sel_src[i].rs1_ready && sel_src[i].rs2_ready;
    end
    disp_woke = snoop(disp_entry);
    disp_kill = flush && cmp_flush_kill(disp_entry.br_tag, flush_tag);
    disp_ok   = !rst && disp_valid && rs_ready && !disp_kill;
    alloc_sel = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_sel = DEPTH'(1) << i;
    end
  end

  rs_age_matrix #(
    .DEPTH (DEPTH)
  ) u_age (
    .clk       (clk),
    .rst       (rst),
    .alloc     (alloc),
    .free_mask (free_mask),
    .req       (req),
    .grant     (grant)
  );

  always_comb begin
    iss_op1      = '0;
    iss_op2      = '0;
    iss_br_tag   = '0;
    iss_dest_rob = '0;
    iss_cmp_type = 1'b0;
    iss_cmp_op   = '0;
    iss_imm      = '0;
    iss_pc       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        iss_op1      |= sel_src[i].rs1_data;
        iss_op2      |= sel_src[i].rs2_data;
        iss_br_tag   |= sel_src[i].br_tag;
        iss_dest_rob |= sel_src[i].dest_rob[ROB_WIDTH-1:0];
        iss_cmp_type |= sel_src[i].cmp_type;
        iss_cmp_op   |= sel_src[i].cmp_op;
        iss_imm      |= sel_src[i].imm;
        iss_pc       |= sel_src[i].pc;
      end
    end
    iss_valid = |grant;
    fire      = iss_valid && iss_ready;
    free_mask = kill | (fire ? grant : '0);
    alloc     = disp_ok ? alloc_sel : '0;
    valid_d   = (valid_q & ~free_mask) | alloc;
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = alloc[i] ? disp_woke : woke[i];
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OccW'(valid_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      entry_q <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

endmodule

// File: tb/tb_res_station_cmp_age.sv
// Scoreboard bench for res_station_cmp_age: directed scenarios plus randomized traffic,
// checked against an age-sequence reference model.
module tb_res_station_cmp_age;
  import res_station_cmp_age_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NCDB  = 2;

  logic          clk = 1'b0;
  logic          rst, flush, disp_valid, rs_ready, iss_valid, iss_ready, iss_cmp_type;
  branch_tag_t   flush_tag, iss_br_tag;
  rs_cmp_entry_t disp_entry;
  CDB_output_t   cdb [NCDB];
  logic [31:0]   iss_op1, iss_op2, iss_imm, iss_pc;
  logic [2:0]    iss_dest_rob, iss_cmp_op, occupancy;

  res_station_cmp_age #(
    .DEPTH     (DEPTH),
    .ROB_WIDTH (3),
    .NUM_CDB   (NCDB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .flush_tag    (flush_tag),
    .disp_valid   (disp_valid),
    .disp_entry   (disp_entry),
    .rs_ready     (rs_ready),
    .cdb          (cdb),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_op1      (iss_op1),
    .iss_op2      (iss_op2),
    .iss_br_tag   (iss_br_tag),
    .iss_dest_rob (iss_dest_rob),
    .iss_cmp_type (iss_cmp_type),
    .iss_cmp_op   (iss_cmp_op),
    .iss_imm      (iss_imm),
    .iss_pc       (iss_pc),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            v;
    rs_cmp_entry_t e;
    int unsigned   seq;
  } m_slot_t;

  typedef struct {
    logic [31:0] op1, op2, imm, pc;
    branch_tag_t tag;
    logic [2:0]  rob, op;
    logic        ty;
  } iss_rec_t;

  m_slot_t     m [DEPTH];
  int unsigned seq_cnt;
  iss_rec_t    exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  event        mon_ev;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_kill(branch_tag_t t, branch_tag_t f);
    if (t[3] == f[3]) return (t & f) == f;
    return (t & f) == t;
  endfunction

  function automatic int cdb_match(logic [31:0] d);
    for (int k = 0; k < NCDB; k++) begin
      if (cdb[k].commit_valid && cdb[k].dest_ROB == d[2:0]) return k;
    end
    return -1;
  endfunction

  function automatic rs_cmp_entry_t m_wake(rs_cmp_entry_t e);
    rs_cmp_entry_t r;
    int k;
    r = e;
    if (!e.rs1_ready) begin
      k = cdb_match(e.rs1_data);
      if (k >= 0) begin r.rs1_ready = 1'b1; r.rs1_data = cdb[k].rd_v; end
    end
    if (!e.rs2_ready) begin
      k = cdb_match(e.rs2_data);
      if (k >= 0) begin r.rs2_ready = 1'b1; r.rs2_data = cdb[k].rd_v; end
    end
    return r;
  endfunction

  function automatic rs_cmp_entry_t mk(bit r1, logic [31:0] d1, bit r2, logic [31:0] d2,
                                       branch_tag_t tag, logic [2:0] rob);
    rs_cmp_entry_t e;
    e.rs1_ready = r1;  e.rs1_data = d1;
    e.rs2_ready = r2;  e.rs2_data = d2;
    e.br_tag    = tag; e.dest_rob = rob;
    e.cmp_type  = rob[0];
    e.cmp_op    = CmpBeq;
    e.imm       = 32'h100 + 32'(rob);
    e.pc        = 32'h4000 + 32'(rob) * 4;
    return e;
  endfunction

  // Evaluate one cycle: compare against the model just before the edge, then advance it.
  task automatic step();
    rs_cmp_entry_t eff [DEPTH];
    rs_cmp_entry_t src [DEPTH];
    bit            kill [DEPTH];
    int            best, slot, cnt;
    iss_rec_t      r;
    #4;
    best = -1; slot = -1; cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      eff[i]  = m_wake(m[i].e);
`ifdef RS_CMP_BYPASS_EN
      src[i]  = eff[i];
`else
      src[i]  = m[i].e;
`endif
      kill[i] = flush && m_kill(m[i].e.br_tag, flush_tag);
      if (m[i].v) cnt++;
      else if (slot < 0) slot = i;
      if (!rst && m[i].v && !kill[i] && src[i].rs1_ready && src[i].rs2_ready)
        if (best < 0 || m[i].seq < m[best].seq) best = i;
    end
    check("iss_valid", iss_valid, best >= 0);
    check("rs_ready", rs_ready, slot >= 0);
    check("occupancy", occupancy, cnt);
    if (best < 0) check("idle_data", {iss_op1, iss_pc}, 64'd0);
    if (best >= 0 && iss_ready) begin
      r.op1 = src[best].rs1_data; r.op2 = src[best].rs2_data;
      r.imm = src[best].imm;      r.pc  = src[best].pc;
      r.tag = src[best].br_tag;   r.rob = src[best].dest_rob;
      r.op  = src[best].cmp_op;   r.ty  = src[best].cmp_type;
      exp_q.push_back(r);
    end
    ->mon_ev;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill[i] || (i == best && iss_ready)) m[i].v = 1'b0;
        else m[i].e = eff[i];
      end
      if (disp_valid && slot >= 0 && !(flush && m_kill(disp_entry.br_tag, flush_tag))) begin
        m[slot].v   = 1'b1;
        m[slot].e   = m_wake(disp_entry);
        m[slot].seq = seq_cnt++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    iss_rec_t r;
    forever begin
      @(mon_ev);
      if (iss_valid && iss_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL issue_order: got issue of rob %0d, expected none", iss_dest_rob);
        end else begin
          r = exp_q.pop_front();
          check("iss_op1", iss_op1, r.op1);
          check("iss_op2", iss_op2, r.op2);
          check("iss_dest_rob", iss_dest_rob, r.rob);
          check("iss_br_tag", iss_br_tag, r.tag);
          check("iss_cmp", {iss_cmp_type, iss_cmp_op}, {r.ty, r.op});
          check("iss_imm_pc", {iss_imm, iss_pc}, {r.imm, r.pc});
        end
      end
    end
  end

  task automatic idle();
    rst = 1'b0; flush = 1'b0; flush_tag = '0; disp_valid = 1'b0;
    for (int k = 0; k < NCDB; k++) cdb[k] = '0;
  endtask

  task automatic disp(rs_cmp_entry_t e);
    disp_valid = 1'b1; disp_entry = e;
    step();
    disp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1; iss_ready = 1'b0; disp_entry = '0;
    for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
    seq_cnt = 0;
    @(negedge clk);
    step();
    rst = 1'b0;
    step();

    // Out-of-order issue: A waits on ROB 2, B ready; cdb[1] later wakes A.
    iss_ready = 1'b1;
    disp(mk(1'b0, 32'd2, 1'b1, 32'd7, 4'b0000, 3'd1));
    disp(mk(1'b1, 32'd5, 1'b1, 32'd5, 4'b0000, 3'd2));
    step();
    cdb[1] = '{commit_valid: 1'b1, dest_ROB: 3'd2, rd_v: 32'h10};
    step();
    idle();
    step(); step();

    // Age order with a stall.
    iss_ready = 1'b0;
    for (int i = 0; i < 4; i++) disp(mk(1'b1, 32'(i), 1'b1, 32'(i + 8), 4'b0000, 3'(i)));
    repeat (3) step();
    iss_ready = 1'b1;
    repeat (5) step();

    // Full: dispatch with dest_rob=7 dropped.
    iss_ready = 1'b0;
    for (int i = 0; i < 4; i++) disp(mk(1'b0, 32'd6, 1'b1, 32'd1, 4'b0000, 3'(i + 1)));
    disp(mk(1'b1, 32'd1, 1'b1, 32'd1, 4'b0000, 3'd7));
    step();
    do_reset();

    // Selective flush: tags 01, 11, 00 against flush tag 01.
    disp(mk(1'b0, 32'd6, 1'b1, 32'd1, 4'b0001, 3'd1));
    disp(mk(1'b0, 32'd6, 1'b1, 32'd1, 4'b0011, 3'd2));
    disp(mk(1'b0, 32'd6, 1'b1, 32'd1, 4'b0000, 3'd3));
    flush = 1'b1; flush_tag = 4'b0001;
    step();
    idle();
    step();
    do_reset();

    // Dispatch/CDB race on ROB 4.
    iss_ready = 1'b1;
    cdb[0] = '{commit_valid: 1'b1, dest_ROB: 3'd4, rd_v: 32'hABCD};
    disp(mk(1'b1, 32'd3, 1'b0, 32'd4, 4'b0000, 3'd5));
    idle();
    step(); step();

    // Reset with three valid entries.
    iss_ready = 1'b0;
    for (int i = 0; i < 3; i++) disp(mk(1'b1, 32'd1, 1'b1, 32'd2, 4'b0000, 3'(i)));
    do_reset();
    iss_ready = 1'b1;
    step(); step();

    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      flush      = ($urandom_range(0, 19) == 0);
      flush_tag  = branch_tag_t'($urandom_range(0, 15));
      disp_valid = ($urandom_range(0, 9) < 6);
      disp_entry = mk(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
                      branch_tag_t'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      disp_entry.cmp_op = 3'($urandom_range(0, 7));
      disp_entry.imm    = $urandom;
      iss_ready  = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < NCDB; k++) begin
        cdb[k].commit_valid = ($urandom_range(0, 9) < 3);
        cdb[k].dest_ROB     = 3'($urandom_range(0, 7));
        cdb[k].rd_v         = $urandom;
      end
      step();
    end
    idle();
    iss_ready = 1'b0;
    step();
    check("queue_drained", exp_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/res_station_cmp_age.md
Name: res_station_cmp_age

Overview:
- Next-generation reservation station for the compare/branch functional unit.
- Generalised to DEPTH entries and NUM_CDB common-data-bus wake-up ports.
- Issues the oldest ready entry through a valid/ready handshake; an age matrix tracks entry order.
- Flush kills only entries whose branch tag depends on the mispredicted branch.
- Sits between dispatch and the compare FU; reports occupancy to dispatch.

Parameters:
- DEPTH, 4: number of entries (2..16).
- ROB_WIDTH, 3: ROB index width; a waiting operand holds its producer ROB number in data[ROB_WIDTH-1:0].
- NUM_CDB, 2: number of CDB broadcast ports checked each cycle.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  branch mispredict kill
- flush_tag  in  branch_tag_t  tag of the mispredicted branch
- disp_valid  in  1  dispatch offers an entry
- disp_entry  in  rs_cmp_entry_t  rs1/rs2 ready+data, br_tag, dest_rob, cmp_type, cmp_op, imm, pc
- rs_ready  out  1  at least one free entry
- cdb  in  CDB_output_t[NUM_CDB]  broadcast results (commit_valid, dest_ROB, rd_v)
- iss_valid  out  1  selected entry presented to the FU
- iss_ready  in  1  FU accepts this cycle
- iss_op1, iss_op2  out  32 each  resolved operands
- iss_br_tag  out  branch_tag_t  tag of the issued entry
- iss_dest_rob  out  ROB_WIDTH  destination ROB index
- iss_cmp_type  out  1  jump (1) or branch (0)
- iss_cmp_op  out  3  compare op
- iss_imm, iss_pc  out  32 each  immediate and PC
- occupancy  out  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Reset: all entries invalid; age matrix cleared.
  - Reset outputs: rs_ready=1, iss_valid=0, occupancy=0, all iss_* data outputs=0.
  - Reset mid-operation discards all entries; nothing issues in the reset cycle.
- rs_ready = OR of free entries, computed from registered valid bits only. It does not look ahead to an entry that issues this cycle.
- Dispatch: on disp_valid && rs_ready, the lowest-index free entry is written.
  - The written entry is marked younger than every valid entry.
  - disp_valid while rs_ready=0 is ignored with no state change.
- Wake-up: each cycle, every valid entry with an operand not ready compares data[ROB_WIDTH-1:0] against each cdb[k] with commit_valid.
  - On a match, the entry latches rd_v and sets the ready bit.
  - If several ports match, the lowest k wins.
  - A dispatching entry also snoops the CDB in its write cycle, so a producer broadcasting that cycle is not missed.
- Ready entry: valid and both operands ready (registered).
- Select: the oldest ready entry per the age matrix.
  - Entry i wins if ready_i and no ready j has older[j][i].
  - iss_* carry that entry; data outputs are 0 when iss_valid=0.
- Issue handshake:
  - iss_valid=1 whenever any ready entry exists, independent of iss_ready.
  - On iss_valid && iss_ready, the entry is freed at the clock edge.
  - Without iss_ready, outputs hold, unless an older entry becomes ready, which then takes priority.
- Latency: dispatch with both operands ready → iss_valid the next cycle. CDB wake-up → issue eligible the next cycle.
- Flush: kill(entry) applies the package function cmp_flush_kill(entry.br_tag, flush_tag):
  - if signs are equal: kill when (tag & flush.tag) == flush.tag;
  - if signs differ: kill when (tag & flush.tag) == tag.
- Flush cycle rules:
  - Killed entries become invalid; surviving entries still wake up normally.
  - A dispatch in a flush cycle is also tested and is not written if killed.
  - A killed entry is excluded from select in that same cycle, so iss_valid deasserts and the next ready survivor is chosen.
- Simultaneous events:
  - Issue and dispatch in the same cycle are both honoured.
  - When full, a freed slot is usable only from the next cycle.
- occupancy: updated each edge as valid count after dispatch, issue and flush.

Optional Feature:
- Macro RS_CMP_BYPASS_EN.
- When defined, an operand arriving on the CDB this cycle counts as ready for select. That entry may issue the same cycle with iss_op* taken from the CDB value; the worst-case path is CDB→issue.
- When undefined, the operand is captured first and issue follows one cycle later.

Decomposition:
- rv32i_types package gets:
  - rs_cmp_entry_t (packed: rs1_ready, rs1_data, rs2_ready, rs2_data, br_tag, dest_rob, cmp_type, cmp_op, imm, pc);
  - function cmp_flush_kill;
  - reuse of existing branch_tag_t and CDB_output_t.
- One sub-module: rs_age_matrix, parameter DEPTH.
  - Inputs: alloc one-hot, free mask, request mask.
  - Output: oldest-grant one-hot.

Test Plan:
- Out-of-order issue:
  - Stimulus: dispatch A (rs1 waits ROB 2), then B (both ready, rs1=5, rs2=5, cmp_op=BEQ), iss_ready=1.
  - Required: B issues the cycle after its dispatch with op1=op2=5; A issues the cycle after cdb[1] broadcasts ROB 2, rd_v=0x10, giving iss_op1=0x10.
- Age order:
  - Stimulus: fill 4 ready entries in order E0..E3, hold iss_ready=0 for 3 cycles, then assert it.
  - Required: iss_dest_rob stays at E0's value while stalled, then issues E0, E1, E2, E3 on consecutive cycles; occupancy goes 4→0.
- Full:
  - Stimulus: 4 entries waiting; disp_valid with dest_rob=7.
  - Required: rs_ready=0, entry dropped, occupancy stays 4.
- Selective flush:
  - Stimulus: entries tagged 0b01, 0b11, 0b00 (same sign); flush_tag=0b01.
  - Required: first two killed, third survives, occupancy 3→1.
- Dispatch/CDB race:
  - Stimulus: dispatch rs2 waiting on ROB 4 while cdb[0] broadcasts ROB 4 with 0xABCD in the same cycle.
  - Required: entry issues next cycle with iss_op2=0xABCD; with RS_CMP_BYPASS_EN it behaves identically.
- Reset mid-run:
  - Stimulus: rst asserted with 3 valid entries.
  - Required: the next cycle shows iss_valid=0, occupancy=0, rs_ready=1.
